// File: rtl/dmem_port_arbiter.sv
// Arbitrates data-memory port 2 between the MEM stage and the serial programmer.
// Programmer writes are buffered in a small FIFO; the CPU has priority with a bounded starvation limit.
module dmem_port_arbiter #(
  parameter int unsigned PROG_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sign,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic        prog_ovf,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic        mem_re,
  output logic [1:0]  mem_size,
  output logic        mem_sign
);

  localparam int unsigned PTR_W = $clog2(PROG_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } prog_entry_t;

  typedef enum logic [0:0] {
    CPU_PRI = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [STV_W-1:0]   starve_cnt;
  logic [STV_W-1:0]   starve_nxt;

  prog_entry_t        fifo_mem [PROG_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  prog_entry_t        fifo_head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_last;
  logic               prog_gnt;
  logic               prog_push;

  assign fifo_head  = fifo_mem[rd_ptr];
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(PROG_FIFO_DEPTH));
  // A pop on the last entry empties the FIFO unless a push lands in the same cycle.
  assign fifo_last  = (fifo_cnt == CNT_W'(1)) && !prog_we;

  // A full FIFO still accepts a push when the head pops in the same cycle.
  assign prog_push  = !RESET && prog_we && (!fifo_full || prog_gnt);

  // Grant selection and next-state; everything is gated off while RESET is high.
  always_comb begin
    cpu_gnt    = 1'b0;
    prog_gnt   = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    if (!RESET) begin
      unique case (state)
        CPU_PRI: begin
          if (fifo_empty) begin
            cpu_gnt    = cpu_req;
            starve_nxt = '0;
          end else if (!cpu_req) begin
            prog_gnt   = 1'b1;
            starve_nxt = '0;
          end else if (starve_cnt == STV_W'(STARVE_LIMIT)) begin
            prog_gnt   = 1'b1;
            starve_nxt = '0;
            if (!fifo_last) state_nxt = DRAIN;
          end else begin
            cpu_gnt    = 1'b1;
            starve_nxt = starve_cnt + STV_W'(1);
          end
        end
        DRAIN: begin
          starve_nxt = '0;
          if (fifo_empty) begin
            state_nxt = CPU_PRI;
          end else begin
            prog_gnt = 1'b1;
            if (fifo_last) state_nxt = CPU_PRI;
          end
        end
        default: state_nxt = CPU_PRI;
      endcase
    end
  end

  assign cpu_stall = !RESET && cpu_req && !cpu_gnt;

  // Port mux: programmer writes are always full words, unsigned.
  always_comb begin
    mem_addr = cpu_addr;
    mem_din  = cpu_wdata;
    mem_size = cpu_size;
    mem_sign = cpu_sign;
    mem_we   = cpu_gnt && cpu_we;
    mem_re   = cpu_gnt && !cpu_we;
    if (prog_gnt) begin
      mem_addr = fifo_head.addr;
      mem_din  = fifo_head.data;
      mem_size = 2'b10;
      mem_sign = 1'b0;
      mem_we   = 1'b1;
      mem_re   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (prog_push) fifo_mem[wr_ptr] <= {prog_addr, prog_data};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= CPU_PRI;
      starve_cnt <= '0;
      cpu_rvalid <= 1'b0;
      prog_ovf   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      if (prog_we && fifo_full && !prog_gnt) prog_ovf <= 1'b1;
      if (prog_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (prog_gnt)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(prog_push) - CNT_W'(prog_gnt);
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: reset, CPU access, drain, starvation, overflow, full push+pop.
module tb_dmem_port_arbiter;

  logic        CLK;
  logic        RESET;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_size;
  logic        cpu_sign;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_ovf;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic        mem_re;
  logic [1:0]  mem_size;
  logic        mem_sign;

  int total = 0;
  int bad   = 0;

  dmem_port_arbiter #(.PROG_FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_sign(cpu_sign),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ovf(prog_ovf),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
    .mem_size(mem_size), .mem_sign(mem_sign)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1;
    cpu_size = 2'b10; cpu_sign = 1'b0; prog_we = 1'b1; prog_addr = 32'h44; prog_data = 32'h55;
    #2;
    total++; if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL rst_cpu_gnt got=%b exp=0", cpu_gnt); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_re !== 1'b0) begin bad++; $display("FAIL rst_mem_re got=%b exp=0", mem_re); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
    tick; tick;
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", cpu_rvalid); end
    total++; if (prog_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", prog_ovf); end
    RESET = 1'b0; cpu_req = 1'b0; prog_we = 1'b0;
    #2;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_no_push got mem_we=%b exp=0", mem_we); end
    tick;
  endtask

  task automatic test_cpu_only;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1000; cpu_size = 2'b10; cpu_sign = 1'b0;
    #2;
    total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL ld_gnt got=%b exp=1", cpu_gnt); end
    total++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL ld_re_we got=%b%b exp=10", mem_re, mem_we); end
    total++; if (mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL ld_addr got=%h exp=00001000", mem_addr); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL ld_stall got=%b exp=0", cpu_stall); end
    tick;
    cpu_we = 1'b1; cpu_addr = 32'h0000_2004; cpu_wdata = 32'h1234_5678; cpu_size = 2'b01; cpu_sign = 1'b1;
    #2;
    total++; if (cpu_rvalid !== 1'b1) begin bad++; $display("FAIL ld_rvalid got=%b exp=1", cpu_rvalid); end
    total++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin bad++; $display("FAIL st_we_re got=%b%b exp=10", mem_we, mem_re); end
    total++; if (mem_din !== 32'h1234_5678 || mem_size !== 2'b01 || mem_sign !== 1'b1) begin
      bad++; $display("FAIL st_fields got din=%h size=%b sign=%b exp 12345678/01/1", mem_din, mem_size, mem_sign); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL st_stall got=%b exp=0", cpu_stall); end
    tick;
    cpu_req = 1'b0; cpu_sign = 1'b0; cpu_size = 2'b10;
    #2;
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL st_rvalid got=%b exp=0", cpu_rvalid); end
    tick;
  endtask

  task automatic test_idle_drain;
    cpu_req = 1'b0; prog_we = 1'b1; prog_addr = 32'h0000_0040; prog_data = 32'hDEAD_BEEF;
    #2;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL idle_early got mem_we=%b exp=0", mem_we); end
    tick;
    prog_we = 1'b0;
    #2;
    total++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin bad++; $display("FAIL idle_we got=%b%b exp=10", mem_we, mem_re); end
    total++; if (mem_addr !== 32'h40 || mem_din !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL idle_data got=%h/%h exp=00000040/deadbeef", mem_addr, mem_din); end
    total++; if (mem_size !== 2'b10 || mem_sign !== 1'b0) begin
      bad++; $display("FAIL idle_size got=%b/%b exp=10/0", mem_size, mem_sign); end
    tick;
    #2;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL idle_empty got mem_we=%b exp=0", mem_we); end
    tick;
  endtask

  task automatic test_starvation;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000;
    prog_we = 1'b1; prog_addr = 32'h80; prog_data = 32'h11;
    #2;
    total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL stv_push_gnt got=%b exp=1", cpu_gnt); end
    tick;
    prog_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      total++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
        bad++; $display("FAIL stv_cpu[%0d] got gnt=%b stall=%b we=%b exp 1/0/0", i, cpu_gnt, cpu_stall, mem_we); end
      tick;
    end
    #2;
    total++; if (cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
      bad++; $display("FAIL stv_force got gnt=%b stall=%b exp 0/1", cpu_gnt, cpu_stall); end
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_din !== 32'h11) begin
      bad++; $display("FAIL stv_force_data got we=%b %h/%h exp 1 00000080/00000011", mem_we, mem_addr, mem_din); end
    tick;
    #2;
    total++; if (cpu_gnt !== 1'b1 || mem_addr !== 32'h3000) begin
      bad++; $display("FAIL stv_resume got gnt=%b addr=%h exp 1/00003000", cpu_gnt, mem_addr); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL stv_rvalid_after_prog got=%b exp=0", cpu_rvalid); end
    tick;
  endtask

  task automatic test_push_full_pop;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000;
    for (int i = 0; i < 9; i++) begin
      prog_we = (i < 4); prog_addr = 32'h100 + 32'(4 * i); prog_data = 32'hA0 + 32'(i);
      #2;
      total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL pfp_cpu[%0d] got=%b exp=1", i, cpu_gnt); end
      tick;
    end
    prog_we = 1'b1; prog_addr = 32'h110; prog_data = 32'hA4;
    #2;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 || cpu_stall !== 1'b1) begin
      bad++; $display("FAIL pfp_force got we=%b addr=%h stall=%b exp 1/00000100/1", mem_we, mem_addr, cpu_stall); end
    tick;
    prog_addr = 32'h114; prog_data = 32'hA5;
    #2;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h104 || cpu_gnt !== 1'b0) begin
      bad++; $display("FAIL pfp_drain_full got we=%b addr=%h gnt=%b exp 1/00000104/0", mem_we, mem_addr, cpu_gnt); end
    tick;
    prog_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if (mem_we !== 1'b1 || mem_addr !== 32'h108 + 32'(4 * i) || mem_din !== 32'hA2 + 32'(i) || cpu_gnt !== 1'b0) begin
        bad++; $display("FAIL pfp_drain[%0d] got we=%b %h/%h gnt=%b exp 1 %h/%h 0", i, mem_we, mem_addr, mem_din, cpu_gnt,
                        32'h108 + 32'(4 * i), 32'hA2 + 32'(i)); end
      tick;
    end
    #2;
    total++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b0) begin
      bad++; $display("FAIL pfp_exit got gnt=%b we=%b exp 1/0", cpu_gnt, mem_we); end
    total++; if (prog_ovf !== 1'b0) begin bad++; $display("FAIL pfp_ovf got=%b exp=0", prog_ovf); end
    tick;
  endtask

  task automatic test_overflow;
    int n;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h6000;
    for (int i = 0; i < 5; i++) begin
      prog_we = 1'b1; prog_addr = 32'h200 + 32'(4 * i); prog_data = 32'hB0 + 32'(i);
      #2;
      total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL ovf_cpu[%0d] got=%b exp=1", i, cpu_gnt); end
      tick;
    end
    prog_we = 1'b0; cpu_req = 1'b0;
    #2;
    total++; if (prog_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", prog_ovf); end
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (mem_we === 1'b1) begin
        total++; if (mem_addr !== 32'h200 + 32'(4 * n) || mem_din !== 32'hB0 + 32'(n)) begin
          bad++; $display("FAIL ovf_write[%0d] got %h/%h exp %h/%h", n, mem_addr, mem_din, 32'h200 + 32'(4 * n), 32'hB0 + 32'(n)); end
        n++;
      end
      tick;
      #2;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", n); end
    tick;
  endtask

  task automatic test_reset_mid_drain;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7000;
    for (int i = 0; i < 10; i++) begin
      prog_we = (i < 4); prog_addr = 32'h300 + 32'(4 * i); prog_data = 32'hC0 + 32'(i);
      tick;
    end
    prog_we = 1'b0;
    #2;
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h304 || cpu_gnt !== 1'b0) begin
      bad++; $display("FAIL rmd_in_drain got we=%b addr=%h gnt=%b exp 1/00000304/0", mem_we, mem_addr, cpu_gnt); end
    RESET = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0 || cpu_stall !== 1'b0 || cpu_gnt !== 1'b0) begin
      bad++; $display("FAIL rmd_async got we=%b stall=%b gnt=%b exp 0/0/0", mem_we, cpu_stall, cpu_gnt); end
    tick;
    RESET = 1'b0; cpu_req = 1'b0;
    #2;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmd_empty got mem_we=%b exp=0", mem_we); end
    total++; if (prog_ovf !== 1'b0) begin bad++; $display("FAIL rmd_ovf got=%b exp=0", prog_ovf); end
    tick;
    cpu_req = 1'b1;
    #2;
    total++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b0) begin
      bad++; $display("FAIL rmd_cpu_pri got gnt=%b we=%b exp 1/0", cpu_gnt, mem_we); end
    tick;
    cpu_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_cpu_only;
    test_idle_drain;
    test_starvation;
    test_push_full_pop;
    test_overflow;
    test_reset_mid_drain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
